mux_bit_serializer_ctrl: RTL and testbench

- Sequencer for the 256-to-1 single-bit select datapath.
- Accepts a 256-bit word plus a start index and a bit count through a valid/ready load port.
- Steps the select line through the word one bit per accepted beat, and emits the bits on a valid/ready serial port.
- Sits between a word-wide producer (register file / capture buffer) and a bit-serial consumer (shift link, scan chain driver).

---
 rtl/mux_bit_serializer_ctrl_pkg.sv | 25 ++
 rtl/mux_bit_serializer_ctrl_if.sv | 34 +++
 rtl/mux_bit_serializer_ctrl_mux256to1.sv | 15 +
 rtl/mux_bit_serializer_ctrl.sv | 123 ++++++++++++
 tb/tb_mux_bit_serializer_ctrl.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/mux_bit_serializer_ctrl_pkg.sv
// mux_ser_pkg: shared constants and types for the bit serializer controller.
//   WIDTH  number of selectable bits (power of two)
//   SEL_W  select index width, log2(WIDTH)
//   CNT_W  bit count width, SEL_W+1 so WIDTH itself fits
//   state_t controller states
//   sat_count() clamps a requested count to WIDTH
package mux_ser_pkg;

    localparam int WIDTH = 256;
    localparam int SEL_W = 8;
    localparam int CNT_W = SEL_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FIN   = 2'd2
    } state_t;

    // Counts above WIDTH are not legal requests; clamp so the job never
    // emits a bit twice.
    function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W-1:0] cnt);
        return (cnt > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : cnt;
    endfunction

endpackage

// File: rtl/mux_bit_serializer_ctrl_if.sv
// mux_ser_if: load port, serial port and status of the bit serializer.
//   load   : ld_valid/ld_ready handshake carrying ld_data, ld_first, ld_count
//   control: abort (synchronous job cancel)
//   serial : ser_valid/ser_ready handshake carrying ser_bit, ser_idx, ser_last
//   status : busy, done
// modport slave is the controller, modport master is its producer/consumer side.
interface mux_ser_if;
    import mux_ser_pkg::*;

    logic             ld_valid;
    logic             ld_ready;
    logic [WIDTH-1:0] ld_data;
    logic [SEL_W-1:0] ld_first;
    logic [CNT_W-1:0] ld_count;
    logic             abort;
    logic             ser_valid;
    logic             ser_ready;
    logic             ser_bit;
    logic [SEL_W-1:0] ser_idx;
    logic             ser_last;
    logic             busy;
    logic             done;

    modport slave (
        input  ld_valid, ld_data, ld_first, ld_count, abort, ser_ready,
        output ld_ready, ser_valid, ser_bit, ser_idx, ser_last, busy, done
    );

    modport master (
        output ld_valid, ld_data, ld_first, ld_count, abort, ser_ready,
        input  ld_ready, ser_valid, ser_bit, ser_idx, ser_last, busy, done
    );

endinterface

// File: rtl/mux_bit_serializer_ctrl_mux256to1.sv
// mux256to1: single-bit select from a WIDTH-bit word.
//   d   : input word
//   sel : bit index
//   y   : d[sel]
module mux256to1
    import mux_ser_pkg::*;
(
    input  logic [WIDTH-1:0] d,
    input  logic [SEL_W-1:0] sel,
    output logic             y
);

    assign y = d[sel];

endmodule

// File: rtl/mux_bit_serializer_ctrl.sv
// mux_bit_serializer_ctrl: steps a select index through a captured word and
// emits one bit per accepted serial beat.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mux_ser_if.slave (load port, abort, serial port, busy/done)
//
// state    | meaning
// ST_IDLE  | ld_ready high, waiting for a load
// ST_SHIFT | ser_valid high, one bit per beat, counting rem_q down
// ST_FIN   | one-cycle done pulse, then back to idle
module mux_bit_serializer_ctrl
    import mux_ser_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    mux_ser_if.slave  bus
);

    state_t           state_q;
    logic [WIDTH-1:0] word_q;
    logic [SEL_W-1:0] sel_q;
    logic [CNT_W-1:0] rem_q;
    logic             ld_ready_q;
    logic             ser_valid_q;
    logic             busy_q;
    logic             done_q;

    logic             sel_bit;
    logic             beat;
    logic             last;
    logic [CNT_W-1:0] ld_cnt_sat;

    mux256to1 u_mux (
        .d   (word_q),
        .sel (sel_q),
        .y   (sel_bit)
    );

    assign beat       = ser_valid_q && bus.ser_ready;
    assign last       = (state_q == ST_SHIFT) && (rem_q == CNT_W'(1));
    assign ld_cnt_sat = sat_count(bus.ld_count);

    assign bus.ld_ready  = ld_ready_q;
    assign bus.ser_valid = ser_valid_q;
    assign bus.ser_bit   = sel_bit;
    assign bus.ser_idx   = sel_q;
    assign bus.ser_last  = last;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            word_q      <= '0;
            sel_q       <= '0;
            rem_q       <= '0;
            ld_ready_q  <= 1'b1;
            ser_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.ld_valid) begin
                        word_q     <= bus.ld_data;
                        sel_q      <= bus.ld_first;
                        rem_q      <= ld_cnt_sat;
                        ld_ready_q <= 1'b0;
                        if (ld_cnt_sat != '0) begin
                            state_q     <= ST_SHIFT;
                            ser_valid_q <= 1'b1;
                            busy_q      <= 1'b1;
                        end else begin
                            state_q <= ST_FIN;
                            done_q  <= 1'b1;
                        end
                    end
                end

                ST_SHIFT: begin
                    // sel_q wraps naturally at WIDTH since SEL_W = log2(WIDTH).
                    if (beat) begin
                        sel_q <= sel_q + SEL_W'(1);
                    end
                    if (bus.abort) begin
                        // A beat taken alongside abort is delivered, but the
                        // job ends without a done pulse.
                        rem_q       <= '0;
                        state_q     <= ST_IDLE;
                        ser_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        ld_ready_q  <= 1'b1;
                    end else if (beat) begin
                        rem_q <= rem_q - CNT_W'(1);
                        if (last) begin
                            state_q     <= ST_FIN;
                            ser_valid_q <= 1'b0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                        end
                    end
                end

                ST_FIN: begin
                    // Completion already happened; abort here changes nothing.
                    state_q    <= ST_IDLE;
                    done_q     <= 1'b0;
                    ld_ready_q <= 1'b1;
                end

                default: begin
                    state_q     <= ST_IDLE;
                    rem_q       <= '0;
                    ld_ready_q  <= 1'b1;
                    ser_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_bit_serializer_ctrl.sv
// Testbench for mux_bit_serializer_ctrl. The reference is the job itself: the
// k-th delivered bit of a job must be ld_data[(first+k) mod 256].
module tb_mux_bit_serializer_ctrl;
    import mux_ser_pkg::*;

    logic clk;
    logic rst_n;

    mux_ser_if bus ();

    mux_bit_serializer_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tot = 0;
    int n_bad = 0;
    bit rdy_pat[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [255:0] rand_word();
        logic [255:0] w;
        for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // Runs one job starting at a negedge with the controller idle.
    // rnd: random ser_ready once rdy_pat is exhausted (else ready high).
    // abort_at: raise abort in the first cycle where k beats have been taken (-1 none).
    // fin_abort: also raise abort during the done cycle (must be ignored).
    task automatic run_job(input logic [255:0] data, input int first, input int count,
                           input bit rnd, input int abort_at, input bit fin_abort);
        int  k;
        int  ie;
        bit  r;
        bit  aborted;
        int  budget;
        k       = 0;
        aborted = 0;
        budget  = 4 * count + 40;

        chk("idle_ld_ready", bus.ld_ready, 1);
        bus.ld_valid = 1'b1;
        bus.ld_data  = data;
        bus.ld_first = SEL_W'(first);
        bus.ld_count = CNT_W'(count);
        bus.abort    = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clk);
        bus.ld_valid = 1'b0;
        bus.abort    = 1'b0;
        bus.ld_data  = ~data;
        bus.ld_first = SEL_W'($urandom);
        bus.ld_count = CNT_W'($urandom_range(1, 256));

        for (int cyc = 0; cyc < budget && k < count && !aborted; cyc++) begin
            ie = (first + k) % WIDTH;
            chk("valid", bus.ser_valid, 1);
            chk("busy", bus.busy, 1);
            chk("ld_ready_busy", bus.ld_ready, 0);
            chk("done_early", bus.done, 0);
            chk("idx", bus.ser_idx, ie);
            chk("bit", bus.ser_bit, data[ie]);
            chk("last", bus.ser_last, (k == count - 1) ? 1 : 0);
            if (rdy_pat.size() > 0) r = rdy_pat.pop_front();
            else if (rnd)           r = 1'($urandom_range(0, 1));
            else                    r = 1'b1;
            bus.ser_ready = r;
            bus.abort     = (k == abort_at) ? 1'b1 : 1'b0;
            @(negedge clk);
            if (bus.abort) aborted = 1;
            if (r) k++;
            bus.ser_ready = 1'b0;
            bus.abort     = 1'b0;
        end

        if (aborted) begin
            chk("abort_valid", bus.ser_valid, 0);
            chk("abort_busy", bus.busy, 0);
            chk("abort_no_done", bus.done, 0);
            chk("abort_ld_ready", bus.ld_ready, 1);
            chk("abort_idx", bus.ser_idx, (first + k) % WIDTH);
        end else if (k < count) begin
            chk("timeout_beats", k, count);
        end else begin
            chk("fin_done", bus.done, 1);
            chk("fin_valid", bus.ser_valid, 0);
            chk("fin_busy", bus.busy, 0);
            chk("fin_ld_ready", bus.ld_ready, 0);
            chk("fin_idx", bus.ser_idx, (first + count) % WIDTH);
            bus.abort = fin_abort;
            @(negedge clk);
            bus.abort = 1'b0;
            chk("post_done", bus.done, 0);
            chk("post_ld_ready", bus.ld_ready, 1);
            chk("post_valid", bus.ser_valid, 0);
        end
    endtask

    initial begin
        logic [255:0] w;
        bus.ld_valid  = 1'b0;
        bus.ld_data   = '0;
        bus.ld_first  = '0;
        bus.ld_count  = '0;
        bus.abort     = 1'b0;
        bus.ser_ready = 1'b0;
        rst_n         = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ld_ready", bus.ld_ready, 1);
        chk("rst_valid", bus.ser_valid, 0);
        chk("rst_bit", bus.ser_bit, 0);
        chk("rst_idx", bus.ser_idx, 0);
        chk("rst_last", bus.ser_last, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic: 0xA5 from bit 0, eight bits.
        w = 256'hA5;
        run_job(w, 0, 8, 0, -1, 0);

        // Wrap: bits 254,255,0,1 set.
        w = '0;
        w[254] = 1'b1; w[255] = 1'b1; w[0] = 1'b1; w[1] = 1'b1;
        run_job(w, 254, 4, 0, -1, 0);
        w = rand_word();
        run_job(w, 250, 10, 0, -1, 0);

        // Backpressure pattern.
        rdy_pat = '{0, 0, 1, 0, 1, 1};
        run_job(rand_word(), 100, 3, 0, -1, 0);
        rdy_pat.delete();

        // Zero and full count.
        run_job(rand_word(), 42, 0, 0, -1, 0);
        run_job(rand_word(), 17, 256, 0, -1, 0);

        // Abort on the 4th beat with ready high.
        run_job(rand_word(), 5, 10, 0, 3, 0);

        // Abort during done cycle is ignored.
        run_job(rand_word(), 9, 2, 0, -1, 1);

        // Reset mid-job with five bits remaining.
        w = rand_word();
        bus.ld_valid = 1'b1;
        bus.ld_data  = w;
        bus.ld_first = 8'd0;
        bus.ld_count = 9'd10;
        @(negedge clk);
        bus.ld_valid  = 1'b0;
        bus.ser_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("pre_rst_idx", bus.ser_idx, 5);
        bus.ser_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", bus.ser_valid, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_ld_ready", bus.ld_ready, 1);
        chk("midrst_idx", bus.ser_idx, 0);
        chk("midrst_last", bus.ser_last, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_job(rand_word(), 77, 6, 0, -1, 0);

        // Randomized jobs.
        for (int j = 0; j < 24; j++) begin
            int cnt;
            int ab;
            cnt = ($urandom_range(0, 9) == 0) ? 256 : $urandom_range(0, 40);
            ab  = ($urandom_range(0, 3) == 0 && cnt > 0) ? $urandom_range(0, cnt - 1) : -1;
            run_job(rand_word(), $urandom_range(0, 255), cnt, 1, ab, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) begin
                chk("gap_ld_ready", bus.ld_ready, 1);
                @(negedge clk);
            end
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
